// File: rtl/mov_block_seq.sv
// MOV sequencer: reg->reg, mem->reg, reg->mem and counted mem->mem block moves,
// ending each move with a single-cycle IF pulse back to instruction fetch.
module mov_block_seq #(
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MOVstr,
    input  logic [3:0]        opCode,
    input  logic [ADDR_W-1:0] srcBase,
    input  logic [ADDR_W-1:0] dstBase,
    input  logic [CNT_W-1:0]  count,
    input  logic              memRdy,
    output logic              IF,
    output logic              DIRiEn,
    output logic              DIRjEn,
    output logic              DBRjEn,
    output logic              RrEn,
    output logic              RwEn,
    output logic              MrEn,
    output logic              MwEn,
    output logic [ADDR_W-1:0] srcAddr,
    output logic [ADDR_W-1:0] dstAddr,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] OP_RR  = 4'b1001;
    localparam logic [3:0] OP_MR  = 4'b1010;
    localparam logic [3:0] OP_RM  = 4'b1011;
    localparam logic [3:0] OP_BLK = 4'b1100;
    localparam int         WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIR,
        S_READ,
        S_XFER,
        S_WRITE,
        S_NEXT,
        S_FETCH
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] src_base_q, dst_base_q;
    logic [CNT_W-1:0]  count_q, remaining;
    logic [WAIT_W-1:0] wait_cnt;
    logic              legal, accept, src_mem, dst_mem, in_wait, timeout;

    assign legal   = (opCode == OP_RR) || (opCode == OP_MR) || (opCode == OP_RM) || (opCode == OP_BLK);
    assign accept  = (state == S_IDLE) && MOVstr && legal;
    assign src_mem = (op_q == OP_MR) || (op_q == OP_BLK);
    assign dst_mem = (op_q == OP_RM) || (op_q == OP_BLK);
    assign in_wait = ((state == S_READ) && src_mem) || ((state == S_WRITE) && dst_mem);
    assign timeout = in_wait && !memRdy && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        IF       = 1'b0;
        DIRiEn   = 1'b0;
        DIRjEn   = 1'b0;
        DBRjEn   = 1'b0;
        RrEn     = 1'b0;
        RwEn     = 1'b0;
        MrEn     = 1'b0;
        MwEn     = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = ((opCode == OP_BLK) && (count == '0)) ? S_FETCH : S_DIR;
                end
            end
            S_DIR: begin
                DIRiEn   = 1'b1;
                DIRjEn   = 1'b1;
                state_nx = S_READ;
            end
            S_READ: begin
                if (src_mem) begin
                    MrEn = 1'b1;
                    if (memRdy) begin
                        state_nx = S_XFER;
                    end else if (timeout) begin
                        state_nx = S_FETCH;
                    end
                end else begin
                    RrEn     = 1'b1;
                    state_nx = S_XFER;
                end
            end
            S_XFER: begin
                DBRjEn   = 1'b1;
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (dst_mem) begin
                    MwEn = 1'b1;
                    if (memRdy) begin
                        state_nx = S_NEXT;
                    end else if (timeout) begin
                        state_nx = S_FETCH;
                    end
                end else begin
                    RwEn     = 1'b1;
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                state_nx = (remaining != CNT_W'(1)) ? S_READ : S_FETCH;
            end
            S_FETCH: begin
                IF       = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            count_q    <= '0;
            remaining  <= '0;
            srcAddr    <= '0;
            dstAddr    <= '0;
            wait_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= opCode;
                src_base_q <= srcBase;
                dst_base_q <= dstBase;
                count_q    <= count;
                err        <= 1'b0;
            end
            if (state == S_DIR) begin
                srcAddr   <= src_base_q;
                dstAddr   <= dst_base_q;
                remaining <= (op_q == OP_BLK) ? count_q : CNT_W'(1);
            end
            // Addresses advance only when another word follows, so they end on the last word moved.
            if (state == S_NEXT) begin
                remaining <= remaining - CNT_W'(1);
                if (remaining != CNT_W'(1)) begin
                    srcAddr <= srcAddr + ADDR_W'(1);
                    dstAddr <= dstAddr + ADDR_W'(1);
                end
            end
            if (timeout) begin
                err <= 1'b1;
            end
            // Any state change restarts the wait counter, so each memory wait starts from zero.
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (in_wait) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mov_block_seq.sv
// Bench for mov_block_seq: directed literal checks plus randomized moves compared every
// cycle against a script-driven behavioural model.
module tb_mov_block_seq;

    localparam int ADDR_W   = 8;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;

    logic              clk;
    logic              reset;
    logic              MOVstr;
    logic [3:0]        opCode;
    logic [ADDR_W-1:0] srcBase;
    logic [ADDR_W-1:0] dstBase;
    logic [CNT_W-1:0]  count;
    logic              memRdy;
    logic              IF, DIRiEn, DIRjEn, DBRjEn, RrEn, RwEn, MrEn, MwEn;
    logic [ADDR_W-1:0] srcAddr, dstAddr;
    logic              busy, err;

    mov_block_seq #(
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .MOVstr (MOVstr),
        .opCode (opCode),
        .srcBase(srcBase),
        .dstBase(dstBase),
        .count  (count),
        .memRdy (memRdy),
        .IF     (IF),
        .DIRiEn (DIRiEn),
        .DIRjEn (DIRjEn),
        .DBRjEn (DBRjEn),
        .RrEn   (RrEn),
        .RwEn   (RwEn),
        .MrEn   (MrEn),
        .MwEn   (MwEn),
        .srcAddr(srcAddr),
        .dstAddr(dstAddr),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit map: [25]IF [24]DIRi [23]DIRj [22]DBR [21]Rr [20]Rw [19]Mr [18]Mw [17]busy [16]err [15:8]src [7:0]dst
    logic [25:0] act_vec;
    assign act_vec = {IF, DIRiEn, DIRjEn, DBRjEn, RrEn, RwEn, MrEn, MwEn, busy, err, srcAddr, dstAddr};

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    localparam logic [7:0] E_IF  = 8'b1000_0000;
    localparam logic [7:0] E_DIR = 8'b0110_0000;
    localparam logic [7:0] E_DBR = 8'b0001_0000;
    localparam logic [7:0] E_RR  = 8'b0000_1000;
    localparam logic [7:0] E_RW  = 8'b0000_0100;
    localparam logic [7:0] E_MR  = 8'b0000_0010;
    localparam logic [7:0] E_MW  = 8'b0000_0001;

    typedef struct {
        logic [7:0] en;
        bit         wt;
        logic [7:0] s;
        logic [7:0] d;
    } step_t;

    step_t      steps[$];
    logic [7:0] last_s = '0;
    logic [7:0] last_d = '0;
    bit         err_m  = 1'b0;
    int         m_wait = 0;

    function automatic bit is_legal(input logic [3:0] op);
        return (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1011) || (op == 4'b1100);
    endfunction

    task automatic push_step(input logic [7:0] en, input bit wt, input logic [7:0] s, input logic [7:0] d);
        step_t t;
        t.en = en;
        t.wt = wt;
        t.s  = s;
        t.d  = d;
        steps.push_back(t);
    endtask

    // A move is a script of per-cycle expected outputs; memory-wait steps repeat until memRdy.
    task automatic build_script(input logic [3:0] op, input logic [7:0] sb, input logic [7:0] db,
                                input logic [3:0] cnt);
        bit sm;
        bit dm;
        int n;
        logic [7:0] s;
        logic [7:0] d;
        sm = (op == 4'b1010) || (op == 4'b1100);
        dm = (op == 4'b1011) || (op == 4'b1100);
        n  = (op == 4'b1100) ? int'(cnt) : 1;
        if (n == 0) begin
            push_step(E_IF, 1'b0, last_s, last_d);
        end else begin
            push_step(E_DIR, 1'b0, last_s, last_d);
            for (int k = 0; k < n; k++) begin
                s = 8'(int'(sb) + k);
                d = 8'(int'(db) + k);
                push_step(sm ? E_MR : E_RR, sm, s, d);
                push_step(E_DBR, 1'b0, s, d);
                push_step(dm ? E_MW : E_RW, dm, s, d);
                push_step(8'h00, 1'b0, s, d);
            end
            push_step(E_IF, 1'b0, 8'(int'(sb) + n - 1), 8'(int'(db) + n - 1));
        end
    endtask

    initial begin
        step_t cur;
        forever begin
            @(posedge clk);
            if (!reset) begin
                steps.delete();
                err_m  = 1'b0;
                last_s = '0;
                last_d = '0;
                m_wait = 0;
            end else if (steps.size() == 0) begin
                if (MOVstr && is_legal(opCode)) begin
                    err_m = 1'b0;
                    build_script(opCode, srcBase, dstBase, count);
                end
            end else begin
                cur    = steps[0];
                last_s = cur.s;
                last_d = cur.d;
                if (cur.wt && !memRdy) begin
                    m_wait++;
                    if (m_wait == WAIT_MAX) begin
                        err_m  = 1'b1;
                        m_wait = 0;
                        steps.delete();
                        push_step(E_IF, 1'b0, cur.s, cur.d);
                    end
                end else begin
                    m_wait = 0;
                    void'(steps.pop_front());
                end
            end
        end
    end

    initial begin
        logic [25:0] exp_vec;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (steps.size() == 0) begin
                    exp_vec = {8'h00, 1'b0, err_m, last_s, last_d};
                end else begin
                    exp_vec = {steps[0].en, 1'b1, err_m, steps[0].s, steps[0].d};
                end
                checks++;
                if (act_vec !== exp_vec) begin
                    failures++;
                    $display("FAIL model_compare t=%0t actual=%h expected=%h", $time, act_vec, exp_vec);
                end
            end
        end
    end

    logic [25:0] obs[1:40];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 (first cycle after the MOVstr edge).
    task automatic start_move(input logic [3:0] op, input logic [7:0] sb, input logic [7:0] db,
                              input logic [3:0] cnt);
        opCode  = op;
        srcBase = sb;
        dstBase = db;
        count   = cnt;
        MOVstr  = 1'b1;
        @(negedge clk);
        MOVstr  = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            obs[c] = act_vec;
            @(negedge clk);
        end
    endtask

    function automatic int first_if(input int n);
        for (int c = 1; c <= n; c++) begin
            if (obs[c][25]) return c;
        end
        return 0;
    endfunction

    function automatic int count_bit(input int pos, input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) s += int'(obs[c][pos]);
        return s;
    endfunction

    initial begin
        int rdy_pct;
        int en_sum;
        reset   = 1'b0;
        MOVstr  = 1'b1;
        opCode  = 4'b1001;
        srcBase = 8'h11;
        dstBase = 8'h22;
        count   = 4'd2;
        memRdy  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", int'(act_vec), 0);
        chk_en = 1'b1;
        MOVstr = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("release_idle", int'(act_vec), 0);

        start_move(4'b1001, 8'd3, 8'd7, 4'd0);
        capture(8);
        chk("rr_dir", int'(obs[1][24:23]), 3);
        chk("rr_read", int'(obs[2][21]), 1);
        chk("rr_xfer", int'(obs[3][22]), 1);
        chk("rr_write", int'(obs[4][20]), 1);
        chk("rr_if_cycle", first_if(8), 6);
        chk("rr_src", int'(obs[6][15:8]), 3);
        chk("rr_dst", int'(obs[6][7:0]), 7);
        chk("rr_err", int'(obs[6][16]), 0);
        chk("rr_busy_fall", int'(obs[7][17]), 0);
        chk("rr_no_mem", count_bit(19, 8) + count_bit(18, 8), 0);

        start_move(4'b1100, 8'hFE, 8'h10, 4'd3);
        capture(16);
        chk("blk_if_cycle", first_if(16), 14);
        chk("blk_mr_count", count_bit(19, 16), 3);
        chk("blk_mw_count", count_bit(18, 16), 3);
        chk("blk_src_w0", int'(obs[2][15:8]), 8'hFE);
        chk("blk_src_w1", int'(obs[6][15:8]), 8'hFF);
        chk("blk_src_w2", int'(obs[10][15:8]), 8'h00);
        chk("blk_dst_w2", int'(obs[10][7:0]), 8'h12);

        memRdy = 1'b0;
        start_move(4'b1010, 8'd5, 8'd9, 4'd0);
        capture(20);
        memRdy = 1'b1;
        chk("to_mr_cycles", count_bit(19, 20), 15);
        chk("to_no_rw", count_bit(20, 20), 0);
        chk("to_if_cycle", first_if(20), 17);
        chk("to_err_at_if", int'(obs[17][16]), 1);
        chk("to_err_sticky", int'(act_vec[16]), 1);

        start_move(4'b0111, 8'd1, 8'd2, 4'd4);
        capture(4);
        chk("illegal_busy", count_bit(17, 4), 0);
        chk("illegal_keeps_err", int'(obs[1][16]), 1);

        start_move(4'b1100, 8'd1, 8'd2, 4'd0);
        capture(3);
        chk("cnt0_if_cycle", first_if(3), 1);
        en_sum = 0;
        for (int b = 18; b <= 24; b++) en_sum += count_bit(b, 3);
        chk("cnt0_no_enables", en_sum, 0);
        chk("cnt0_err_clear", int'(obs[1][16]), 0);
        chk("cnt0_busy_fall", int'(obs[2][17]), 0);

        memRdy = 1'b0;
        start_move(4'b1011, 8'd4, 8'd6, 4'd0);
        capture(4);
        chk("mid_in_write", int'(act_vec[18]), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_zero", int'(act_vec), 0);
        reset  = 1'b1;
        memRdy = 1'b1;
        capture(6);
        chk("mid_no_if", first_if(6), 0);
        chk("mid_no_busy", count_bit(17, 6), 0);

        start_move(4'b1001, 8'd3, 8'd7, 4'd0);
        capture(1);
        MOVstr  = 1'b1;
        opCode  = 4'b1100;
        srcBase = 8'h55;
        count   = 4'd5;
        @(negedge clk);
        MOVstr = 1'b0;
        capture(6);
        chk("strobe_if_cycle", first_if(6), 4);
        chk("strobe_src", int'(obs[4][15:8]), 3);

        rdy_pct = 95;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: rdy_pct = 95;
                    1: rdy_pct = 60;
                    default: rdy_pct = 0;
                endcase
            end
            memRdy = ($urandom_range(0, 99) < rdy_pct);
            MOVstr = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: opCode = 4'b1001;
                1: opCode = 4'b1010;
                2: opCode = 4'b1011;
                4: opCode = 4'($urandom);
                default: opCode = 4'b1100;
            endcase
            srcBase = 8'($urandom);
            dstBase = 8'($urandom);
            count   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            reset   = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end

        reset  = 1'b1;
        MOVstr = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
